// File: rtl/counter_8b.sv
// -----------------------------------------------------------------------------
// counter_8b
//
// Free-running up-counter with enable, synchronous clear and a terminal-count
// flag. Used as a generic event / timebase counter in a single clock domain.
//
// Build option:
//   COUNTER_8B_SATURATE_EN  - when defined, the counter holds at TERM_VAL
//                             instead of wrapping, and overflow becomes a
//                             level that stays high while parked at TERM_VAL
//                             with count_en asserted. Undefined (default):
//                             wrap to 0 with a one-cycle overflow pulse.
//
// Parameters:
//   WIDTH     - counter width in bits
//   TERM_VAL  - terminal count (wrap / saturation point)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset, clears count
//   count_en  in   increment by one per clock while high
//   count_clr in   synchronous clear, wins over count_en
//   count     out  registered counter value
//   overflow  out  count==TERM_VAL with an enabled, uncleared increment
//                  pending; combinational from count and the inputs
// -----------------------------------------------------------------------------
module counter_8b #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TERM_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             count_clr,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    logic at_term;

    assign at_term = (count == TERM_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count_clr) begin
            count <= '0;
        end else if (count_en) begin
            if (at_term) begin
`ifdef COUNTER_8B_SATURATE_EN
                count <= TERM_VAL;
`else
                count <= '0;
`endif
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

    // Announces the wrap (or, in saturating mode, the parked state) in the
    // same cycle as the terminal value, so downstream logic can act on the
    // edge that wraps. rst_n is included so the flag is low throughout reset
    // even if count_en is driven high.
    assign overflow = at_term && count_en && !count_clr && rst_n;

endmodule

// File: tb/tb_counter_8b.sv
module tb_counter_8b;

    logic       clk;
    logic       rst_n;
    logic       count_en;
    logic       count_clr;
    logic [7:0] count;
    logic       overflow;

    int checks;
    int failures;

    counter_8b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_en  (count_en),
        .count_clr (count_clr),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then move 1 time unit away from it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b1;
        count_en  = 1'b0;
        count_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 8'h00) begin
            failures++;
            $display("FAIL reset_async count=%h expected=00", count);
        end
        // Enable high during reset must not raise overflow or count.
        count_en = 1'b1;
        tick;
        tick;
        checks++;
        if (count !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold count=%h overflow=%b expected=00/0", count, overflow);
        end
        count_en = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (count !== 8'h00 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d count=%h overflow=%b expected=00/0",
                         i, count, overflow);
            end
        end
    endtask

    task automatic test_count_wrap;
        logic [7:0] exp;
        exp      = 8'h00;
        count_en = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick;
            exp = exp + 8'h01;
            checks++;
            if (count !== exp || overflow !== (exp == 8'hFF)) begin
                failures++;
                $display("FAIL count_up step=%0d count=%h overflow=%b expected=%h/%b",
                         i, count, overflow, exp, (exp == 8'hFF));
            end
        end
        tick;
        checks++;
        if (count !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap count=%h overflow=%b expected=00/0", count, overflow);
        end
        for (int i = 0; i < 10; i++) tick;
        checks++;
        if (count !== 8'h0A || overflow !== 1'b0) begin
            failures++;
            $display("FAIL post_wrap count=%h overflow=%b expected=0a/0", count, overflow);
        end
    endtask

    task automatic test_clear;
        // Get to 0A from wherever we are.
        count_clr = 1'b1;
        tick;
        count_clr = 1'b0;
        count_en  = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        checks++;
        if (count !== 8'h0A) begin
            failures++;
            $display("FAIL clear_setup count=%h expected=0a", count);
        end
        count_clr = 1'b1;
        tick;
        checks++;
        if (count !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL clear_first count=%h overflow=%b expected=00/0", count, overflow);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if (count !== 8'h00 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL clear_held cyc=%0d count=%h overflow=%b expected=00/0",
                         i, count, overflow);
            end
        end
        count_clr = 1'b0;
        tick;
        checks++;
        if (count !== 8'h01) begin
            failures++;
            $display("FAIL clear_release count=%h expected=01", count);
        end
    endtask

    task automatic test_hold_at_term;
        count_clr = 1'b1;
        tick;
        count_clr = 1'b0;
        count_en  = 1'b1;
        for (int i = 0; i < 255; i++) tick;
        checks++;
        if (count !== 8'hFF || overflow !== 1'b1) begin
            failures++;
            $display("FAIL reach_ff count=%h overflow=%b expected=ff/1", count, overflow);
        end
        count_en = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_en_low overflow=%b expected=0", overflow);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (count !== 8'hFF || overflow !== 1'b0) begin
                failures++;
                $display("FAIL hold_ff cyc=%0d count=%h overflow=%b expected=ff/0",
                         i, count, overflow);
            end
        end
        // Clear masks the flag combinationally at FF.
        count_en  = 1'b1;
        count_clr = 1'b1;
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_masked_by_clr overflow=%b expected=0", overflow);
        end
        count_clr = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_comb overflow=%b expected=1", overflow);
        end
        count_en = 1'b0;
        #1;
    endtask

    task automatic test_async_reset;
        // Entered with count parked at FF and count_en low.
        tick;
        count_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset count=%h overflow=%b expected=00/0", count, overflow);
        end
        #2;
        rst_n = 1'b1;
        tick;
        checks++;
        if (count !== 8'h01) begin
            failures++;
            $display("FAIL resume_after_reset count=%h expected=01", count);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] en_pat;
        logic [7:0] exp;
        en_pat    = 4'b1101;
        count_clr = 1'b1;
        tick;
        count_clr = 1'b0;
        exp       = 8'h00;
        for (int i = 0; i < 4; i++) begin
            count_en = en_pat[i];
            tick;
            if (en_pat[i]) exp = exp + 8'h01;
            checks++;
            if (count !== exp) begin
                failures++;
                $display("FAIL en_toggle step=%0d count=%h expected=%h", i, count, exp);
            end
        end
        count_en = 1'b0;
    endtask

`ifdef COUNTER_8B_SATURATE_EN
    task automatic test_saturate;
        logic [7:0] exp;
        count_clr = 1'b1;
        tick;
        count_clr = 1'b0;
        count_en  = 1'b1;
        exp       = 8'h00;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (exp != 8'hFF) exp = exp + 8'h01;
            checks++;
            if (count !== exp || overflow !== (exp == 8'hFF)) begin
                failures++;
                $display("FAIL saturate step=%0d count=%h overflow=%b expected=%h/%b",
                         i, count, overflow, exp, (exp == 8'hFF));
            end
        end
        count_clr = 1'b1;
        tick;
        checks++;
        if (count !== 8'h00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL saturate_clear count=%h overflow=%b expected=00/0", count, overflow);
        end
        count_clr = 1'b0;
        count_en  = 1'b0;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
`ifdef COUNTER_8B_SATURATE_EN
        test_saturate;
`else
        test_count_wrap;
`endif
        test_clear;
        test_hold_at_term;
        test_async_reset;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
